// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
//
// Register-file front end for an SPI slave. The first byte of each chip-select
// window is a command: bit7 selects read (1) or write (0). Bits[ADDR_W-1:0]
// give the start address. Bits[6:ADDR_W] must be zero, otherwise the
// transaction is discarded and counted as an error.
// Write transactions store the following bytes into the register file.
// Read transactions load tx_data for the SPI slave to shift out.
// The last register (NREG-1) is a read-only window onto stat_in.
//
// Optional feature: define SPI_REG_AUTOINC_EN to advance the address pointer
// (wrapping) after every data byte. Without it, the pointer stays on the start
// address for the whole transaction.
//
// Ports:
//   clk27m     in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   cs         in   chip select, active-low, already synchronised
//   rx_data    in   [7:0] byte received by the SPI slave
//   data_valid in   one-cycle pulse, rx_data valid
//   stat_in    in   [7:0] read-only status for register NREG-1
//   tx_data    out  [7:0] next byte for the SPI slave to send
//   tx_start   out  one-cycle pulse, tx_data newly loaded
//   reg_q      out  [8*NREG-1:0] all registers, reg i at [8i+7:8i]
//   busy       out  high whenever the FSM is not IDLE
//   err_cnt    out  [3:0] saturating count of rejected command bytes
// -----------------------------------------------------------------------------
module spi_reg_ctrl #(
    parameter int         ADDR_W  = 3,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic                       clk27m,
    input  logic                       rst,
    input  logic                       cs,
    input  logic [7:0]                 rx_data,
    input  logic                       data_valid,
    input  logic [7:0]                 stat_in,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    output logic [8*(2**ADDR_W)-1:0]   reg_q,
    output logic                       busy,
    output logic [3:0]                 err_cnt
);

    localparam int                NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG-1);

    typedef enum logic [2:0] {IDLE, CMD, WR, RD, DISCARD} state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  ptr_reg, ptr_next, ptr_step;
    logic [7:0]         tx_data_reg;
    logic               tx_start_reg;
    logic [3:0]         err_cnt_reg;
    // Cleared by reset, set once cs is seen high: a transaction cut short by
    // reset must not resume until the master has ended its cs window.
    logic               armed_reg;

    logic               wr_en;
    logic               rd_load;
    logic               err_inc;
    logic [6:0]         cmd_hi;
    logic               cmd_bad;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [7:0]         rd_val;

    assign cmd_hi   = rx_data[6:0] >> ADDR_W;
    assign cmd_bad  = |cmd_hi;
    assign cmd_addr = rx_data[ADDR_W-1:0];

`ifdef SPI_REG_AUTOINC_EN
    assign ptr_step = ptr_reg + ADDR_W'(1);   // natural wrap NREG-1 -> 0
`else
    assign ptr_step = ptr_reg;
`endif

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk27m) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM next state / strobes ----------------
    // cs high wins over a coincident data_valid, so a byte that arrives while
    // the window closes is neither written nor answered.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        wr_en      = 1'b0;
        rd_load    = 1'b0;
        err_inc    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!cs && armed_reg) state_next = CMD;
            end
            CMD: begin
                if (cs) begin
                    state_next = IDLE;
                end else if (data_valid) begin
                    if (cmd_bad) begin
                        state_next = DISCARD;
                        err_inc    = 1'b1;
                    end else if (rx_data[7]) begin
                        state_next = RD;
                        ptr_next   = cmd_addr;
                        rd_load    = 1'b1;
                    end else begin
                        state_next = WR;
                        ptr_next   = cmd_addr;
                    end
                end
            end
            WR: begin
                if (cs) begin
                    state_next = IDLE;
                end else if (data_valid) begin
                    wr_en    = 1'b1;
                    ptr_next = ptr_step;
                end
            end
            RD: begin
                if (cs) begin
                    state_next = IDLE;
                end else if (data_valid) begin
                    ptr_next = ptr_step;
                    rd_load  = 1'b1;
                end
            end
            DISCARD: begin
                if (cs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Read data follows the pointer value being loaded this cycle.
    assign rd_val = (ptr_next == LAST) ? stat_in : reg_q[{ptr_next, 3'b000} +: 8];

    // ---------------- datapath ----------------
    always_ff @(posedge clk27m) begin
        if (rst) begin
            ptr_reg      <= '0;
            tx_data_reg  <= 8'h00;
            tx_start_reg <= 1'b0;
            err_cnt_reg  <= 4'd0;
            armed_reg    <= 1'b0;
        end else begin
            ptr_reg      <= ptr_next;
            tx_start_reg <= rd_load;
            if (rd_load) tx_data_reg <= rd_val;
            if (err_inc && err_cnt_reg != 4'hF) err_cnt_reg <= err_cnt_reg + 4'd1;
            if (cs) armed_reg <= 1'b1;
        end
    end

    // ---------------- register file ----------------
    // The top register has no storage: writes to it vanish, and its reg_q
    // slot shows the reset value. Reads of it are redirected to stat_in above.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        if (gi == NREG-1) begin : g_ro
            assign reg_q[8*gi +: 8] = RST_VAL;
        end else begin : g_rw
            logic [7:0] val_reg;
            always_ff @(posedge clk27m) begin
                if (rst) begin
                    val_reg <= RST_VAL;
                end else if (wr_en && ptr_reg == ADDR_W'(gi)) begin
                    val_reg <= rx_data;
                end
            end
            assign reg_q[8*gi +: 8] = val_reg;
        end
    end

    assign tx_data  = tx_data_reg;
    assign tx_start = tx_start_reg;
    assign err_cnt  = err_cnt_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_ctrl
//
// Directed testbench for spi_reg_ctrl with the default parameters
// (ADDR_W = 3, RST_VAL = 8'h00). Expected values are hand-computed.
// Results that depend on SPI_REG_AUTOINC_EN are selected with the same macro.
// Inputs are driven on the falling edge, and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_spi_reg_ctrl;

    logic        clk27m = 1'b0;
    logic        rst;
    logic        cs;
    logic [7:0]  rx_data;
    logic        data_valid;
    logic [7:0]  stat_in;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [63:0] reg_q;
    logic        busy;
    logic [3:0]  err_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q;

    spi_reg_ctrl dut (
        .clk27m     (clk27m),
        .rst        (rst),
        .cs         (cs),
        .rx_data    (rx_data),
        .data_valid (data_valid),
        .stat_in    (stat_in),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .reg_q      (reg_q),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    always #19 clk27m = ~clk27m;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic cs_low();
        cs = 1'b0;
        @(negedge clk27m);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        @(negedge clk27m);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data    = b;
        data_valid = 1'b1;
        @(negedge clk27m);
        data_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; rx_data = 8'h00; data_valid = 1'b0; stat_in = 8'h00;
        exp_q = '0;
        repeat (3) @(negedge clk27m);
        check_val("rst_reg_q",    reg_q,    64'h0);
        check_val("rst_tx_data",  tx_data,  8'h00);
        check_val("rst_tx_start", tx_start, 1'b0);
        check_val("rst_busy",     busy,     1'b0);
        check_val("rst_err_cnt",  err_cnt,  4'd0);
        rst = 1'b0;
        @(negedge clk27m);

        // Write 02, A5, 3C
        cs_low();
        check_val("wr_busy", busy, 1'b1);
        send_byte(8'h02);
        check_val("wr_cmd_noreg", reg_q, 64'h0);
        send_byte(8'hA5);
        send_byte(8'h3C);
        cs_high();
`ifdef SPI_REG_AUTOINC_EN
        exp_q[23:16] = 8'hA5; exp_q[31:24] = 8'h3C;
`else
        exp_q[23:16] = 8'h3C;
`endif
        check_val("wr_reg_q", reg_q, exp_q);
        check_val("wr_idle_busy", busy, 1'b0);
        $display("txn write 02 A5 3C reg_q=%h", reg_q);

        // Preload reg1 = 11, reg2 = 22
        cs_low(); send_byte(8'h01); send_byte(8'h11); cs_high();
        cs_low(); send_byte(8'h02); send_byte(8'h22); cs_high();
        exp_q[15:8] = 8'h11; exp_q[23:16] = 8'h22;
        check_val("preload_reg_q", reg_q, exp_q);
        $display("txn preload reg1=11 reg2=22 reg_q=%h", reg_q);

        // Read from 1
        cs_low();
        send_byte(8'h81);
        check_val("rd0_start", tx_start, 1'b1);
        check_val("rd0_data",  tx_data,  8'h11);
        @(negedge clk27m);
        check_val("rd0_start_off", tx_start, 1'b0);
        check_val("rd0_hold",      tx_data,  8'h11);
        send_byte(8'h00);
        check_val("rd1_start", tx_start, 1'b1);
`ifdef SPI_REG_AUTOINC_EN
        check_val("rd1_data", tx_data, 8'h22);
`else
        check_val("rd1_data", tx_data, 8'h11);
`endif
        cs_high();
        $display("txn read 81 00 last tx_data=%h", tx_data);

        // Wrap and status
        stat_in = 8'h5A;
        cs_low();
        send_byte(8'h87);
        check_val("wrap0_data", tx_data, 8'h5A);
        send_byte(8'h00);
`ifdef SPI_REG_AUTOINC_EN
        check_val("wrap1_data", tx_data, 8'h00);
`else
        check_val("wrap1_data", tx_data, 8'h5A);
`endif
        send_byte(8'h00);
`ifdef SPI_REG_AUTOINC_EN
        check_val("wrap2_data", tx_data, 8'h11);
`else
        check_val("wrap2_data", tx_data, 8'h5A);
`endif
        cs_high();
        $display("txn read 87 00 00 last tx_data=%h", tx_data);
        cs_low(); send_byte(8'h07); send_byte(8'h77); cs_high();
        check_val("wr_ro_reg_q", reg_q, exp_q);
        $display("txn write 07 77 reg_q=%h", reg_q);

        // data_valid in IDLE is ignored
        send_byte(8'h00);
        send_byte(8'h99);
        check_val("idle_dv_busy",  busy,  1'b0);
        check_val("idle_dv_reg_q", reg_q, exp_q);
        $display("txn idle bytes 00 99 ignored");

        // Bad command
        cs_low();
        send_byte(8'h48);
        check_val("bad_busy",    busy,    1'b1);
        check_val("bad_err_cnt", err_cnt, 4'd1);
        send_byte(8'h02);
        send_byte(8'hA5);
        check_val("bad_ignored", reg_q, exp_q);
        cs_high();
        $display("txn bad 48 err_cnt=%0d", err_cnt);
        for (int i = 0; i < 15; i++) begin
            cs_low(); send_byte(8'h48); cs_high();
            if (i == 13) check_val("bad_cnt_15", err_cnt, 4'd15);
        end
        check_val("bad_cnt_sat", err_cnt, 4'd15);
        $display("txn 15 more bad commands err_cnt=%0d", err_cnt);

        // Abort: cs high coinciding with a byte
        cs_low();
        send_byte(8'h04);
        cs = 1'b1;
        send_byte(8'hFF);
        check_val("abort_busy",     busy,     1'b0);
        check_val("abort_tx_start", tx_start, 1'b0);
        check_val("abort_reg_q",    reg_q,    exp_q);
        $display("txn abort write 04 FF reg_q=%h", reg_q);

        // Reset after the command byte of a write
        cs_low();
        send_byte(8'h05);
        rst = 1'b1;
        rx_data = 8'hEE; data_valid = 1'b1;
        @(negedge clk27m);
        rst = 1'b0; data_valid = 1'b0;
        exp_q = '0;
        check_val("mrst_reg_q",   reg_q,   exp_q);
        check_val("mrst_tx_data", tx_data, 8'h00);
        check_val("mrst_err_cnt", err_cnt, 4'd0);
        check_val("mrst_busy",    busy,    1'b0);
        send_byte(8'h03);
        send_byte(8'h99);
        check_val("mrst_not_armed_busy",  busy,  1'b0);
        check_val("mrst_not_armed_reg_q", reg_q, exp_q);
        cs_high();
        cs_low();
        check_val("mrst_rearm_busy", busy, 1'b1);
        send_byte(8'h03);
        send_byte(8'h99);
        cs_high();
        exp_q[31:24] = 8'h99;
        check_val("mrst_rearm_reg_q", reg_q, exp_q);
        $display("txn reset mid-write then write 03 99 reg_q=%h", reg_q);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
